// File: rtl/recovery_restore_seq.sv
// Restore sequencer: on voter total collapse, halts the three replicas and
// copies the recovery register file into their register files.
module recovery_restore_seq #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int FIRST_REG   = 1,
  parameter int HALT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              collapse_in,
  output logic [ADDR_W-1:0] rec_addr,
  input  logic [DATA_W-1:0] rec_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wd,
  output logic              core_halt,
  output logic              busy,
  output logic              restore_done,
  output logic [7:0]        restore_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int CW = (HALT_CYCLES < 2) ? 1 : $clog2(HALT_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(HALT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] A_FIRST = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] A_LAST = '1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          pending;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state         <= S_IDLE;
      cnt           <= '0;
      pending       <= 1'b0;
      rec_addr      <= '0;
      rf_we         <= 1'b0;
      rf_addr       <= '0;
      rf_wd         <= '0;
      core_halt     <= 1'b0;
      busy          <= 1'b0;
      restore_done  <= 1'b0;
      restore_count <= '0;
    end else begin
      restore_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          rec_addr <= '0;
          rf_we    <= 1'b0;
          if (collapse_in) begin
            state     <= S_HALT;
            core_halt <= 1'b1;
            busy      <= 1'b1;
            cnt       <= '0;
          end
        end
        S_HALT: begin
          if (collapse_in) pending <= 1'b1;
          if (cnt >= C_LAST) begin
            state    <= S_SWEEP;
            rec_addr <= A_FIRST;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SWEEP: begin
          if (collapse_in) pending <= 1'b1;
          rf_we   <= 1'b1;
          rf_addr <= rec_addr;
          rf_wd   <= rec_data;
          if (rec_addr == A_LAST) state <= S_DRAIN;
          else rec_addr <= rec_addr + 1'b1;
        end
        S_DRAIN: begin
          if (collapse_in) pending <= 1'b1;
          rf_we        <= 1'b0;
          rec_addr     <= '0;
          state        <= S_DONE;
          restore_done <= 1'b1;
          if (restore_count != 8'hFF)
            restore_count <= restore_count + 8'd1;
        end
        S_DONE: begin
          if (pending || collapse_in) begin
            // Cores are already stalled, so DONE counts as one settle cycle.
            pending <= 1'b0;
            state   <= S_HALT;
            cnt     <= CW'(1);
          end else begin
            state     <= S_IDLE;
            core_halt <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          core_halt <= 1'b0;
          busy      <= 1'b0;
          rf_we     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_recovery_restore_seq.sv
// Directed bench for recovery_restore_seq: default instance plus a
// FIRST_REG=0 / HALT_CYCLES=1 instance.
module tb_recovery_restore_seq;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        col_a = 1'b0;
  logic        col_b = 1'b0;

  logic [4:0]  rec_addr, rf_addr;
  logic [31:0] rec_data, rf_wd;
  logic        rf_we, core_halt, busy, restore_done;
  logic [7:0]  restore_count;

  logic [4:0]  rec_addr_b, rf_addr_b;
  logic [31:0] rec_data_b, rf_wd_b;
  logic        rf_we_b, core_halt_b, busy_b, restore_done_b;
  logic [7:0]  restore_count_b;

  always #5 clk = ~clk;

  assign rec_data   = 32'hA5A50000 + 32'(rec_addr);
  assign rec_data_b = 32'hA5A50000 + 32'(rec_addr_b);

  recovery_restore_seq dut (
    .clk(clk), .rst_in(rst_in), .collapse_in(col_a),
    .rec_addr(rec_addr), .rec_data(rec_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wd(rf_wd),
    .core_halt(core_halt), .busy(busy),
    .restore_done(restore_done), .restore_count(restore_count)
  );

  recovery_restore_seq #(.FIRST_REG(0), .HALT_CYCLES(1)) dut_b (
    .clk(clk), .rst_in(rst_in), .collapse_in(col_b),
    .rec_addr(rec_addr_b), .rec_data(rec_data_b),
    .rf_we(rf_we_b), .rf_addr(rf_addr_b), .rf_wd(rf_wd_b),
    .core_halt(core_halt_b), .busy(busy_b),
    .restore_done(restore_done_b), .restore_count(restore_count_b)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int e0 = 0;

  int wr_cnt, first_wr, last_wr, ord_err, data_err, zero_err;
  int halt_len, done_n;
  int done_c [2];
  bit have_last;
  logic [4:0] last_addr;

  int wr_b, first_b, last_b, ord_b, data_b, halt_b, done_b_n, done_b_c;
  int first_addr_b;
  bit have_b;
  logic [4:0] last_addr_b;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    wr_cnt = 0; first_wr = -1; last_wr = -1; ord_err = 0;
    data_err = 0; zero_err = 0; halt_len = 0; done_n = 0;
    done_c[0] = -1; done_c[1] = -1; have_last = 0; last_addr = '0;
    wr_b = 0; first_b = -1; last_b = -1; ord_b = 0; data_b = 0;
    halt_b = 0; done_b_n = 0; done_b_c = -1; first_addr_b = -1;
    have_b = 0; last_addr_b = '0;
  endtask

  task automatic sample();
    if (rf_we) begin
      if (wr_cnt == 0) first_wr = cyc - e0;
      last_wr = cyc - e0;
      if (have_last && rf_addr != last_addr + 5'd1) ord_err++;
      if (!have_last && rf_addr != 5'd1) ord_err++;
      if (rf_addr == 5'd0) zero_err++;
      if (rf_wd != 32'hA5A50000 + 32'(rf_addr)) data_err++;
      last_addr = rf_addr;
      have_last = 1;
      wr_cnt++;
    end
    if (core_halt) halt_len++;
    if (restore_done) begin
      if (done_n < 2) done_c[done_n] = cyc - e0;
      done_n++;
      have_last = 0;
    end
    if (rf_we_b) begin
      if (wr_b == 0) begin
        first_b = cyc - e0;
        first_addr_b = int'(rf_addr_b);
      end
      last_b = cyc - e0;
      if (have_b && rf_addr_b != last_addr_b + 5'd1) ord_b++;
      if (rf_wd_b != 32'hA5A50000 + 32'(rf_addr_b)) data_b++;
      last_addr_b = rf_addr_b;
      have_b = 1;
      wr_b++;
    end
    if (core_halt_b) halt_b++;
    if (restore_done_b) begin
      if (done_b_n == 0) done_b_c = cyc - e0;
      done_b_n++;
      have_b = 0;
    end
  endtask

  task automatic tick(input logic a, input logic b);
    col_a = a;
    col_b = b;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    col_a = 1'b0;
    col_b = 1'b0;
    sample();
  endtask

  task automatic run_idle(input int bound, output bit to);
    int n = 0;
    while ((busy || busy_b) && n < bound) begin
      tick(1'b0, 1'b0);
      n++;
    end
    to = busy || busy_b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_in = 1'b0;
    @(negedge clk);
    rst_in = 1'b1;
    clear_stats();
  endtask

  typedef struct {
    int          k;
    logic        col;
    logic        halt;
    logic        bsy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic        done;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl [11];

  initial begin
    bit to;
    int k;
    int to_cnt;

    tbl[0]  = '{0,  1'b1, 1, 1, 0, 5'd0,  32'h0,        5'd0,  0, 8'd0};
    tbl[1]  = '{1,  1'b0, 1, 1, 0, 5'd0,  32'h0,        5'd0,  0, 8'd0};
    tbl[2]  = '{2,  1'b0, 1, 1, 0, 5'd0,  32'h0,        5'd1,  0, 8'd0};
    tbl[3]  = '{3,  1'b0, 1, 1, 1, 5'd1,  32'hA5A50001, 5'd2,  0, 8'd0};
    tbl[4]  = '{4,  1'b0, 1, 1, 1, 5'd2,  32'hA5A50002, 5'd3,  0, 8'd0};
    tbl[5]  = '{17, 1'b0, 1, 1, 1, 5'd15, 32'hA5A5000F, 5'd16, 0, 8'd0};
    tbl[6]  = '{32, 1'b0, 1, 1, 1, 5'd30, 32'hA5A5001E, 5'd31, 0, 8'd0};
    tbl[7]  = '{33, 1'b0, 1, 1, 1, 5'd31, 32'hA5A5001F, 5'd31, 0, 8'd0};
    tbl[8]  = '{34, 1'b0, 1, 1, 0, 5'd0,  32'h0,        5'd0,  1, 8'd1};
    tbl[9]  = '{35, 1'b0, 0, 0, 0, 5'd0,  32'h0,        5'd0,  0, 8'd1};
    tbl[10] = '{36, 1'b0, 0, 0, 0, 5'd0,  32'h0,        5'd0,  0, 8'd1};

    clear_stats();
    #3;
    check("rst_rec_addr", 32'(rec_addr), 0);
    check("rst_rf_we", 32'(rf_we), 0);
    check("rst_rf_addr", 32'(rf_addr), 0);
    check("rst_rf_wd", rf_wd, 0);
    check("rst_halt", 32'(core_halt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(restore_done), 0);
    check("rst_count", 32'(restore_count), 0);

    // basic restore, table driven
    do_reset();
    tick(1'b0, 1'b0);
    k = -1;
    for (int i = 0; i < 11; i++) begin
      while (k < tbl[i].k) begin
        k++;
        tick((k == tbl[i].k) ? tbl[i].col : 1'b0, 1'b0);
        if (k == 0) e0 = cyc;
      end
      check($sformatf("row%0d_halt", i), 32'(core_halt), 32'(tbl[i].halt));
      check($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      check($sformatf("row%0d_we", i), 32'(rf_we), 32'(tbl[i].we));
      check($sformatf("row%0d_ra", i), 32'(rec_addr), 32'(tbl[i].ra));
      check($sformatf("row%0d_done", i), 32'(restore_done),
            32'(tbl[i].done));
      check($sformatf("row%0d_cnt", i), 32'(restore_count),
            32'(tbl[i].cnt));
      if (tbl[i].we) begin
        check($sformatf("row%0d_wa", i), 32'(rf_addr), 32'(tbl[i].wa));
        check($sformatf("row%0d_wd", i), rf_wd, tbl[i].wd);
      end
    end
    check("basic_wr_cnt", wr_cnt, 31);
    check("basic_first_wr", first_wr, 3);
    check("basic_last_wr", last_wr, 33);
    check("basic_halt_len", halt_len, 35);
    check("basic_done_n", done_n, 1);
    check("basic_done_at", done_c[0], 34);
    check("basic_order", ord_err, 0);
    check("basic_x0", zero_err, 0);
    check("basic_data", data_err, 0);

    // collapse during sweep
    do_reset();
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    e0 = cyc;
    repeat (11) tick(1'b0, 1'b0);
    check("s2_rec_addr10", 32'(rec_addr), 10);
    tick(1'b1, 1'b0);
    run_idle(200, to);
    check("s2_timeout", 32'(to), 0);
    check("s2_done_n", done_n, 2);
    check("s2_done0", done_c[0], 34);
    check("s2_done1", done_c[1], 68);
    check("s2_wr_cnt", wr_cnt, 62);
    check("s2_halt_len", halt_len, 69);
    check("s2_order", ord_err, 0);
    check("s2_data", data_err, 0);
    check("s2_count", 32'(restore_count), 2);

    // asynchronous reset mid-sweep
    clear_stats();
    tick(1'b1, 1'b0);
    e0 = cyc;
    repeat (21) tick(1'b0, 1'b0);
    check("s3_rec_addr20", 32'(rec_addr), 20);
    #2 rst_in = 1'b0;
    #1;
    check("s3_rec_addr", 32'(rec_addr), 0);
    check("s3_rf_we", 32'(rf_we), 0);
    check("s3_rf_addr", 32'(rf_addr), 0);
    check("s3_rf_wd", rf_wd, 0);
    check("s3_halt", 32'(core_halt), 0);
    check("s3_busy", 32'(busy), 0);
    check("s3_done", 32'(restore_done), 0);
    check("s3_count", 32'(restore_count), 0);
    repeat (2) tick(1'b0, 1'b0);
    rst_in = 1'b1;
    clear_stats();
    repeat (6) tick(1'b0, 1'b0);
    check("s3_idle_busy", 32'(busy), 0);
    check("s3_idle_halt", halt_len, 0);
    check("s3_idle_wr", wr_cnt, 0);
    check("s3_idle_done", done_n, 0);

    // saturation
    do_reset();
    to_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      tick(1'b1, 1'b0);
      e0 = cyc;
      run_idle(60, to);
      if (to) to_cnt++;
      if (i == 254) check("sat_count_255", 32'(restore_count), 255);
    end
    check("sat_timeout", to_cnt, 0);
    check("sat_count", 32'(restore_count), 255);
    check("sat_done_n", done_n, 256);

    // FIRST_REG=0, HALT_CYCLES=1
    do_reset();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    e0 = cyc;
    run_idle(200, to);
    check("p_timeout", 32'(to), 0);
    check("p_wr_cnt", wr_b, 32);
    check("p_first_addr", first_addr_b, 0);
    check("p_first_wr", first_b, 2);
    check("p_last_wr", last_b, 33);
    check("p_halt_len", halt_b, 35);
    check("p_done_at", done_b_c, 34);
    check("p_order", ord_b, 0);
    check("p_data", data_b, 0);
    check("p_count", 32'(restore_count_b), 1);
    check("p_a_quiet", wr_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
